pulse_width_meter: RTL and testbench
====================================

Name: pulse_width_meter

Overview:
- Measures the high time of a single-bit pulse by counting enabled clock ticks.
- It is the receiving end of the monostable one-shot emulation: a one-shot pulse of C enabled ticks reads back as WIDTH = C.
- Used by discrete-logic game models to decode timer pulses, e.g. to drive score, motion or sound logic from a measured duration, and as a loopback checker for one-shot timers.

Parameters:
- BW, 32, width of the counter, MAX_COUNTS and WIDTH.

Ports:
- CLK  input  1  system clock; all state changes on its rising edge.
- RST_N  input  1  asynchronous active-low reset.
- PULSE  input  1  pulse being measured, active high, synchronous to CLK.
- COUNT_EN  input  1  tick enable; the counter advances only on cycles where this is 1.
- MAX_COUNTS  input  BW  saturation limit; 0 means no limit (saturate at all-ones).
- ABORT  input  1  synchronous cancel of a measurement in progress.
- BUSY  output  1  high while a measurement is in progress.
- VALID  output  1  one-cycle strobe; WIDTH/OVF are new this cycle.
- WIDTH  output  BW  last measured width in enabled ticks.
- OVF  output  1  last measurement hit the saturation limit.

Behaviour:
- Reset (RST_N=0, asynchronous):
  - state=IDLE, counter=0, WIDTH=0, OVF=0.
  - prev_pulse=1, so a PULSE already high when reset releases is not measured.
- Edge detection:
  - prev_pulse registers PULSE every cycle.
  - rise = ~prev_pulse & PULSE.
  - The measurement ends when PULSE=0 is sampled in MEAS.
- Limit: LIM = (MAX_COUNTS==0) ? all-ones : MAX_COUNTS.
- States:
  - IDLE: counter=0. On rise: counter <= COUNT_EN ? 1 : 0, next MEAS. The detect cycle is counted.
  - MEAS, PULSE=1, ABORT=0: if COUNT_EN and counter<LIM, counter+1; else counter holds (saturates at LIM).
  - MEAS, PULSE=0, ABORT=0: WIDTH <= counter, OVF <= (counter==LIM), next REPORT.
  - MEAS, ABORT=1: next IDLE, counter=0, WIDTH/OVF unchanged, no VALID. ABORT wins over a simultaneous PULSE=0. A re-measure needs a fresh rise.
  - REPORT (one cycle): on rise, counter <= COUNT_EN ? 1 : 0, next MEAS, with no lost edge on a 1-cycle low gap. Otherwise counter=0, next IDLE. ABORT is ignored in REPORT.
  - Unused encodings go to IDLE.
- Outputs:
  - BUSY = (state==MEAS); VALID = (state==REPORT). Both decoded from the state register, so they are glitch-free and have no combinational path from inputs.
  - WIDTH and OVF are registered and hold until the next REPORT.
- Latency:
  - VALID asserts 1 cycle after the first cycle PULSE is sampled low.
  - A PULSE high for N consecutive cycles with COUNT_EN=1 gives WIDTH=N (N>=1), if N<=LIM.
- Width rules:
  - No wrap-around; the counter saturates at LIM.
  - OVF=1 also when the width exactly equals LIM. This is intentional: it flags a possibly clipped value.
- MAX_COUNTS is sampled every cycle. If it is lowered below counter mid-measurement, counter holds and the report gives WIDTH=counter, OVF=0; LIM is not re-applied.
- Reset asserted mid-MEAS: immediate return to IDLE, no VALID, WIDTH/OVF cleared.

Test Plan:
- Basic: COUNT_EN=1; PULSE low 3 cycles, high 7, low -> one VALID cycle 1 cycle after the fall, WIDTH=7, OVF=0; BUSY high for exactly 7 cycles.
- Enable gating: COUNT_EN toggling 1,0,1,0; PULSE high 10 cycles, detect cycle has COUNT_EN=1 -> WIDTH=5; COUNT_EN=0 throughout -> WIDTH=0, VALID still strobes.
- Saturation: MAX_COUNTS=4, PULSE high 20 cycles, COUNT_EN=1 -> WIDTH=4, OVF=1. Repeat with a 4-cycle pulse -> WIDTH=4, OVF=1. A 3-cycle pulse -> WIDTH=3, OVF=0. MAX_COUNTS=0 with BW=4 and a 40-cycle pulse -> WIDTH=15, OVF=1.
- Back-to-back: PULSE high 5, low 1, high 6, low -> two VALID strobes, WIDTH=5 then WIDTH=6; second measurement starts from REPORT.
- Abort/reset: ABORT during a pulse -> BUSY drops next cycle, no VALID, WIDTH keeps its prior value; the remainder of that pulse is not measured. RST_N low mid-pulse -> outputs 0 immediately; PULSE still high at release -> no measurement until PULSE falls and rises again.
- Loopback: one-shot timer with COUNTS=100, COUNT_EN=1, output driving PULSE -> WIDTH=100, OVF=0 with MAX_COUNTS=0.

Source files
------------

// File: rtl/pulse_width_meter.sv
// Pulse high-time meter: counts enabled clock ticks while PULSE is high and
// reports the width (with a saturation flag) in a one-cycle VALID strobe.
module pulse_width_meter #(
    parameter int BW = 32
) (
    input  logic          CLK,
    input  logic          RST_N,
    input  logic          PULSE,
    input  logic          COUNT_EN,
    input  logic [BW-1:0] MAX_COUNTS,
    input  logic          ABORT,
    output logic          BUSY,
    output logic          VALID,
    output logic [BW-1:0] WIDTH,
    output logic          OVF,
    output logic [1:0]    DBG_STATE
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MEAS   = 2'd1,
        REPORT = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [BW-1:0] cnt_q, cnt_d;
    logic [BW-1:0] width_q, width_d;
    logic          ovf_q, ovf_d;
    logic          prev_q;
    logic [BW-1:0] lim;
    logic [BW-1:0] first_tick;
    logic          rise;

    // Handshake: VALID is a single-cycle strobe with no ready; WIDTH/OVF are
    // new in that cycle and hold until the next strobe.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            width_q <= '0;
            ovf_q   <= 1'b0;
            prev_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            width_q <= width_d;
            ovf_q   <= ovf_d;
            prev_q  <= PULSE;
        end
    end

    always_comb begin
        lim        = (MAX_COUNTS == '0) ? '1 : MAX_COUNTS;
        rise       = ~prev_q & PULSE;
        first_tick = {{(BW-1){1'b0}}, COUNT_EN};
        state_d    = IDLE;
        cnt_d      = '0;
        width_d    = width_q;
        ovf_d      = ovf_q;
        case (state_q)
            IDLE: begin
                if (rise) begin
                    state_d = MEAS;
                    cnt_d   = first_tick;
                end
            end
            MEAS: begin
                if (ABORT) begin
                    state_d = IDLE;
                end else if (PULSE) begin
                    state_d = MEAS;
                    // A limit lowered below the count just freezes it.
                    if (COUNT_EN && (cnt_q < lim))
                        cnt_d = cnt_q + {{(BW-1){1'b0}}, 1'b1};
                    else
                        cnt_d = cnt_q;
                end else begin
                    state_d = REPORT;
                    width_d = cnt_q;
                    ovf_d   = (cnt_q == lim);
                end
            end
            REPORT: begin
                if (rise) begin
                    state_d = MEAS;
                    cnt_d   = first_tick;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign BUSY      = (state_q == MEAS);
    assign VALID     = (state_q == REPORT);
    assign WIDTH     = width_q;
    assign OVF       = ovf_q;
    assign DBG_STATE = state_q;

endmodule

// File: tb/tb_pulse_width_meter.sv
// Directed bench for pulse_width_meter: table of single-pulse measurements
// plus hand-written back-to-back, abort, limit-change, loopback and reset cases.
module tb_pulse_width_meter;

  logic        clk;
  logic        rst_n;
  logic        pulse_drv;
  logic        pulse;
  logic        count_en;
  logic [31:0] max_counts;
  logic        abort_in;
  logic        busy, valid, ovf;
  logic [31:0] width;
  logic [1:0]  dbg_state;
  logic        busy4, valid4, ovf4;
  logic [3:0]  width4;
  logic [1:0]  dbg_state4;

  logic        loop_mode;
  logic        os_trig;
  int          os_cnt = 0;

  int          n_cmp;
  int          n_fail;
  int          busy_cnt;
  logic [31:0] got_q[$];
  logic        got_o;
  logic [3:0]  got_w4;
  logic        got_o4;

  typedef struct {
    int          n;
    int          en_mode;
    logic [31:0] maxc;
    logic [31:0] exp_w;
    logic        exp_o;
    logic [3:0]  exp_w4;
    logic        exp_o4;
  } vec_t;

  vec_t vecs[9];

  assign pulse = loop_mode ? (os_cnt != 0) : pulse_drv;

  pulse_width_meter #(.BW(32)) dut (
    .CLK(clk), .RST_N(rst_n), .PULSE(pulse), .COUNT_EN(count_en),
    .MAX_COUNTS(max_counts), .ABORT(abort_in), .BUSY(busy), .VALID(valid),
    .WIDTH(width), .OVF(ovf), .DBG_STATE(dbg_state)
  );

  pulse_width_meter #(.BW(4)) dut4 (
    .CLK(clk), .RST_N(rst_n), .PULSE(pulse), .COUNT_EN(count_en),
    .MAX_COUNTS(4'd0), .ABORT(abort_in), .BUSY(busy4), .VALID(valid4),
    .WIDTH(width4), .OVF(ovf4), .DBG_STATE(dbg_state4)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // one-shot timer model used for the loopback case
  always @(posedge clk) begin
    if (os_trig) os_cnt <= 100;
    else if (os_cnt != 0 && count_en) os_cnt <= os_cnt - 1;
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // drive inputs at a falling edge, then sample outputs at the next one
  task automatic cyc(input logic p, input logic e, input logic a);
    pulse_drv = p;
    count_en  = e;
    abort_in  = a;
    @(negedge clk);
    if (valid) begin
      got_q.push_back(width);
      got_o  = ovf;
      got_w4 = width4;
      got_o4 = ovf4;
    end
    if (busy) busy_cnt++;
  endtask

  task automatic clear_mon();
    got_q.delete();
    busy_cnt = 0;
    got_o  = 1'bx;
    got_w4 = 4'hx;
    got_o4 = 1'bx;
  endtask

  task automatic run_pulse(input int n, input int en_mode);
    logic e;
    repeat (3) cyc(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < n; i++) begin
      e = (en_mode == 0) ? 1'b1 : (en_mode == 1) ? ((i % 2) == 0) : 1'b0;
      cyc(1'b1, e, 1'b0);
    end
    repeat (4) cyc(1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    logic [31:0] first_w;
    n_cmp      = 0;
    n_fail     = 0;
    rst_n      = 1'b0;
    pulse_drv  = 1'b0;
    count_en   = 1'b0;
    max_counts = 32'd0;
    abort_in   = 1'b0;
    loop_mode  = 1'b0;
    os_trig    = 1'b0;
    clear_mon();

    vecs[0] = '{7,   0, 32'd0,   32'd7,   1'b0, 4'd7,  1'b0};
    vecs[1] = '{10,  1, 32'd0,   32'd5,   1'b0, 4'd5,  1'b0};
    vecs[2] = '{10,  2, 32'd0,   32'd0,   1'b0, 4'd0,  1'b0};
    vecs[3] = '{20,  0, 32'd4,   32'd4,   1'b1, 4'd15, 1'b1};
    vecs[4] = '{4,   0, 32'd4,   32'd4,   1'b1, 4'd4,  1'b0};
    vecs[5] = '{3,   0, 32'd4,   32'd3,   1'b0, 4'd3,  1'b0};
    vecs[6] = '{1,   0, 32'd0,   32'd1,   1'b0, 4'd1,  1'b0};
    vecs[7] = '{40,  0, 32'd0,   32'd40,  1'b0, 4'd15, 1'b1};
    vecs[8] = '{100, 0, 32'd100, 32'd100, 1'b1, 4'd15, 1'b1};

    repeat (2) @(negedge clk);
    chk("reset_busy",  {31'd0, busy},  32'd0);
    chk("reset_valid", {31'd0, valid}, 32'd0);
    chk("reset_width", width,          32'd0);
    chk("reset_ovf",   {31'd0, ovf},   32'd0);
    chk("reset_state", {30'd0, dbg_state}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int v = 0; v < 9; v++) begin
      clear_mon();
      max_counts = vecs[v].maxc;
      run_pulse(vecs[v].n, vecs[v].en_mode);
      chk($sformatf("vec%0d_valid_count", v), got_q.size(), 32'd1);
      first_w = (got_q.size() > 0) ? got_q[0] : 32'hxxxx_xxxx;
      chk($sformatf("vec%0d_width", v), first_w, vecs[v].exp_w);
      chk($sformatf("vec%0d_ovf", v), {31'd0, got_o}, {31'd0, vecs[v].exp_o});
      chk($sformatf("vec%0d_busy_cycles", v), busy_cnt, vecs[v].n);
      chk($sformatf("vec%0d_width_bw4", v), {28'd0, got_w4}, {28'd0, vecs[v].exp_w4});
      chk($sformatf("vec%0d_ovf_bw4", v), {31'd0, got_o4}, {31'd0, vecs[v].exp_o4});
    end
    max_counts = 32'd0;

    // back-to-back pulses separated by a single low cycle
    clear_mon();
    repeat (3) cyc(1'b0, 1'b1, 1'b0);
    repeat (5) cyc(1'b1, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b0);
    repeat (6) cyc(1'b1, 1'b1, 1'b0);
    repeat (4) cyc(1'b0, 1'b1, 1'b0);
    chk("b2b_valid_count", got_q.size(), 32'd2);
    chk("b2b_width_first",  (got_q.size() > 0) ? got_q[0] : 32'hxxxx_xxxx, 32'd5);
    chk("b2b_width_second", (got_q.size() > 1) ? got_q[1] : 32'hxxxx_xxxx, 32'd6);

    // abort mid-pulse, then abort coinciding with the fall
    run_pulse(9, 0);
    clear_mon();
    repeat (3) cyc(1'b0, 1'b1, 1'b0);
    repeat (4) cyc(1'b1, 1'b1, 1'b0);
    chk("abort_busy_before", {31'd0, busy}, 32'd1);
    cyc(1'b1, 1'b1, 1'b1);
    chk("abort_busy_drop", {31'd0, busy}, 32'd0);
    busy_cnt = 0;
    repeat (5) cyc(1'b1, 1'b1, 1'b0);
    repeat (4) cyc(1'b0, 1'b1, 1'b0);
    chk("abort_no_valid", got_q.size(), 32'd0);
    chk("abort_no_remeasure_busy", busy_cnt, 32'd0);
    chk("abort_width_kept", width, 32'd9);
    repeat (4) cyc(1'b1, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b1);
    repeat (4) cyc(1'b0, 1'b1, 1'b0);
    chk("abort_on_fall_no_valid", got_q.size(), 32'd0);
    chk("abort_on_fall_width_kept", width, 32'd9);

    // limit lowered below the running count
    clear_mon();
    repeat (3) cyc(1'b0, 1'b1, 1'b0);
    repeat (6) cyc(1'b1, 1'b1, 1'b0);
    max_counts = 32'd3;
    repeat (2) cyc(1'b1, 1'b1, 1'b0);
    repeat (4) cyc(1'b0, 1'b1, 1'b0);
    chk("limdrop_valid_count", got_q.size(), 32'd1);
    chk("limdrop_width", (got_q.size() > 0) ? got_q[0] : 32'hxxxx_xxxx, 32'd6);
    chk("limdrop_ovf", {31'd0, got_o}, 32'd0);
    max_counts = 32'd0;

    // loopback from a 100-tick one-shot
    clear_mon();
    loop_mode = 1'b1;
    os_trig   = 1'b1;
    cyc(1'b0, 1'b1, 1'b0);
    os_trig   = 1'b0;
    repeat (110) cyc(1'b0, 1'b1, 1'b0);
    loop_mode = 1'b0;
    chk("loop_valid_count", got_q.size(), 32'd1);
    chk("loop_width", (got_q.size() > 0) ? got_q[0] : 32'hxxxx_xxxx, 32'd100);
    chk("loop_ovf", {31'd0, got_o}, 32'd0);

    // asynchronous reset in the middle of a pulse
    clear_mon();
    repeat (3) cyc(1'b0, 1'b1, 1'b0);
    repeat (4) cyc(1'b1, 1'b1, 1'b0);
    chk("rst_busy_before", {31'd0, busy}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_busy_now",  {31'd0, busy}, 32'd0);
    chk("rst_width_now", width, 32'd0);
    chk("rst_ovf_now",   {31'd0, ovf}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    busy_cnt = 0;
    repeat (5) cyc(1'b1, 1'b1, 1'b0);
    chk("rst_high_release_busy", busy_cnt, 32'd0);
    repeat (3) cyc(1'b0, 1'b1, 1'b0);
    chk("rst_high_release_no_valid", got_q.size(), 32'd0);
    repeat (3) cyc(1'b1, 1'b1, 1'b0);
    repeat (4) cyc(1'b0, 1'b1, 1'b0);
    chk("rst_after_valid_count", got_q.size(), 32'd1);
    chk("rst_after_width", (got_q.size() > 0) ? got_q[0] : 32'hxxxx_xxxx, 32'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
